// File: rtl/sr_ignition_sequencer.sv
// Ignition sequencer: derives beta_quiet, supplies the base threshold, and
// runs the arm / ramp / plateau / fall / refractory envelope that shapes the
// Q14 ignition gain, counting ignitions and flagging conscious access once.
module sr_ignition_sequencer #(
  parameter int WIDTH          = 18,
  parameter int FRAC           = 14,
  parameter int BASE_THRESH    = 9830,
  parameter int BETA_QUIET_LO  = 3277,
  parameter int BETA_QUIET_HI  = 4915,
  parameter int BQ_DWELL       = 8,
  parameter int ARM_CYCLES     = 4,
  parameter int RAMP_STEP      = 2048,
  parameter int PLATEAU_CYCLES = 16,
  parameter int REFRACT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] coherence,
  input  logic signed [WIDTH-1:0] beta_power,
  input  logic signed [WIDTH-1:0] ignition_threshold,
  input  logic                    ignition_permitted,
  input  logic                    consciousness_access_possible,
  output logic                    beta_quiet,
  output logic signed [WIDTH-1:0] base_threshold,
  output logic                    ignition_active,
  output logic [2:0]              ignition_phase,
  output logic signed [WIDTH-1:0] ignition_gain,
  output logic [15:0]             event_count,
  output logic                    consciousness_event
);

  localparam int CW = 16;

  localparam logic signed [WIDTH-1:0] BASE_W = WIDTH'(BASE_THRESH);
  localparam logic signed [WIDTH-1:0] LO_W   = WIDTH'(BETA_QUIET_LO);
  localparam logic signed [WIDTH-1:0] HI_W   = WIDTH'(BETA_QUIET_HI);
  localparam logic signed [WIDTH-1:0] ONE_W  = WIDTH'(1 << FRAC);

  // Gain arithmetic runs one bit wider so a step past full scale or below
  // zero is seen as such and clamped rather than wrapping.
  localparam logic signed [WIDTH:0] STEP_X = (WIDTH+1)'(RAMP_STEP);
  localparam logic signed [WIDTH:0] ONE_X  = (WIDTH+1)'(1 << FRAC);
  localparam logic signed [WIDTH:0] ZERO_X = '0;

  localparam logic [CW-1:0] DWELL_C   = CW'(BQ_DWELL);
  localparam logic [CW-1:0] DWELL_M1  = CW'(BQ_DWELL - 1);
  localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_CYCLES - 1);
  localparam logic [CW-1:0] PLAT_LAST = CW'(PLATEAU_CYCLES - 1);
  localparam logic [CW-1:0] REF_LAST  = CW'(REFRACT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    RISE       = 3'd2,
    PLATEAU    = 3'd3,
    FALL       = 3'd4,
    REFRACTORY = 3'd5
  } state_t;

  state_t                 state;
  logic [CW-1:0]          bq_cnt;
  logic [CW-1:0]          arm_cnt;
  logic [CW-1:0]          phase_cnt;
  logic                   consc_latch;
  logic                   en_ok;
  logic                   perm_ok;
  logic                   access_ok;
  logic                   cond;
  logic signed [WIDTH:0]  gain_up;
  logic signed [WIDTH:0]  gain_dn;

  // Single-bit controls count only when they are a clean 1; anything else
  // (including unknowns from an unreset upstream block) reads as 0.
  assign en_ok     = (clk_en === 1'b1);
  assign perm_ok   = (ignition_permitted === 1'b1);
  assign access_ok = (consciousness_access_possible === 1'b1);
  assign cond      = perm_ok && ((coherence >= ignition_threshold) === 1'b1);

  assign gain_up = {ignition_gain[WIDTH-1], ignition_gain} + STEP_X;
  assign gain_dn = {ignition_gain[WIDTH-1], ignition_gain} - STEP_X;

  assign ignition_phase = state;

  // Beta-quiet dwell counter with LO/HI hysteresis, plus the constant base threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      bq_cnt         <= '0;
      beta_quiet     <= 1'b0;
      base_threshold <= BASE_W;
    end else if (en_ok) begin
      base_threshold <= BASE_W;
      if (beta_power < LO_W) begin
        if (bq_cnt != DWELL_C) bq_cnt <= bq_cnt + CW'(1);
        if (bq_cnt >= DWELL_M1) beta_quiet <= 1'b1;
      end else begin
        bq_cnt <= '0;
        if (beta_power > HI_W) beta_quiet <= 1'b0;
      end
    end
  end

  // Ignition envelope FSM with registered gain, activity, event count and access pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      arm_cnt             <= '0;
      phase_cnt           <= '0;
      consc_latch         <= 1'b0;
      ignition_active     <= 1'b0;
      ignition_gain       <= '0;
      event_count         <= '0;
      consciousness_event <= 1'b0;
    end else if (!en_ok) begin
      consciousness_event <= 1'b0;
    end else begin
      consciousness_event <= 1'b0;
      case (state)
        IDLE: begin
          if (cond) begin
            state   <= ARM;
            arm_cnt <= CW'(1);
          end
        end
        ARM: begin
          if (!cond) begin
            state   <= IDLE;
            arm_cnt <= '0;
          end else if (arm_cnt == ARM_LAST) begin
            state           <= RISE;
            arm_cnt         <= '0;
            consc_latch     <= 1'b0;
            ignition_active <= 1'b1;
            if (event_count != 16'hFFFF) event_count <= event_count + 16'd1;
          end else begin
            arm_cnt <= arm_cnt + CW'(1);
          end
        end
        RISE: begin
          if (!beta_quiet) begin
            state <= FALL;
          end else if (gain_up >= ONE_X) begin
            ignition_gain <= ONE_W;
            state         <= PLATEAU;
            phase_cnt     <= '0;
          end else begin
            ignition_gain <= gain_up[WIDTH-1:0];
          end
        end
        PLATEAU: begin
          if (access_ok && !consc_latch) begin
            consciousness_event <= 1'b1;
            consc_latch         <= 1'b1;
          end
          if (!beta_quiet || phase_cnt == PLAT_LAST) begin
            state     <= FALL;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        FALL: begin
          if (gain_dn <= ZERO_X) begin
            ignition_gain   <= '0;
            state           <= REFRACTORY;
            phase_cnt       <= '0;
            ignition_active <= 1'b0;
          end else begin
            ignition_gain <= gain_dn[WIDTH-1:0];
          end
        end
        REFRACTORY: begin
          if (phase_cnt == REF_LAST) begin
            state     <= IDLE;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        default: begin
          state           <= IDLE;
          ignition_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
